// File: rtl/aes_iter_ctrl.sv
// aes_iter_ctrl: iterative AES-encrypt sequencer.
// One external combinational round unit is reused for all Nr rounds. This
// block owns the 128-bit state, the round counter (which is also the
// round-key index) and the in/out valid-ready handshakes. It holds at most
// one block in flight.
//
// Round-key schedule seen by the key source on rk_idx_o:
//   IDLE : 0          (initial addRoundKey is folded into the accept edge)
//   RUN  : 1 .. Nr    (rnd_final_o is high only on round Nr)
//   DONE : Nr         (rk_in_i / rnd_out_i are ignored here)
//
// Every output comes straight from a register. The only input-to-output
// path is the external one through the round unit.
// Legal parameters: Nr >= 1 and 2**RW > Nr.
module aes_iter_ctrl #(
  parameter int Nr = 10,
  parameter int RW = 4
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  // block request side
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [127:0]  in_data_i,
  // key source (combinational, same-cycle)
  output logic [RW-1:0] rk_idx_o,
  input  logic [127:0]  rk_in_i,
  // round unit (combinational from rnd_state_o, rnd_final_o, rk_in_i)
  output logic [127:0]  rnd_state_o,
  output logic          rnd_final_o,
  input  logic [127:0]  rnd_out_i,
  // ciphertext side
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [127:0]  out_data_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [RW-1:0] LastRound = RW'(Nr);
  localparam logic [RW-1:0] OneRound  = RW'(1);

  fsm_e          fsm_q;
  logic [127:0]  state_q;
  logic [RW-1:0] round_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          rnd_final_q;

  // Next round number and final-round detect. round_q is never incremented
  // once it equals LastRound, so the sum cannot wrap.
  logic [RW-1:0] round_d;
  logic          last_round;

  assign round_d    = round_q + OneRound;
  assign last_round = (round_q == LastRound);

  // Controller FSM: state register, round counter and registered handshake flags.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rnd_final_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid_i) begin
            // Initial addRoundKey with round key 0 (rk_idx_o is 0 in IDLE).
            state_q     <= in_data_i ^ rk_in_i;
            round_q     <= OneRound;
            rnd_final_q <= (LastRound == OneRound);
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            fsm_q       <= RUN;
          end
        end

        RUN: begin
          // One round per cycle through the shared round unit.
          state_q <= rnd_out_i;
          if (last_round) begin
            // Keep round_q at Nr; it is cleared on the output handshake.
            rnd_final_q <= 1'b0;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            round_q     <= round_d;
            rnd_final_q <= (round_d == LastRound);
          end
        end

        DONE: begin
          // state_q is frozen here so out_data_o stays stable under backpressure.
          // No accept in the same cycle as the handshake: one block in flight.
          if (out_ready_i) begin
            round_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end

        default: begin
          // Unreachable encoding: recover to the reset condition.
          state_q     <= '0;
          round_q     <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          rnd_final_q <= 1'b0;
          fsm_q       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign rnd_final_o = rnd_final_q;
  assign rk_idx_o    = round_q;
  assign rnd_state_o = state_q;
  assign out_data_o  = state_q;

  // Protocol invariants.
  a_out_hold: assert property (@(posedge clk_i) disable iff (!reset_ni)
    (out_valid_q && !out_ready_i) |=> (out_valid_q && $stable(state_q)));

  a_run_round_nz: assert property (@(posedge clk_i) disable iff (!reset_ni)
    (fsm_q == RUN) |-> (round_q != '0));

  a_round_bound: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(round_q > LastRound));

  a_ready_busy_excl: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(in_ready_q && busy_q));

  a_final_only_last: assert property (@(posedge clk_i) disable iff (!reset_ni)
    rnd_final_q |-> ((fsm_q == RUN) && last_round));

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb_aes_iter_ctrl: directed bench for the iterative AES sequencer.
// A behavioural AES round unit and key expansion close the loop around two
// controller instances (Nr=10 with FIPS-197 C.1, Nr=14 with C.3).
module tb_aes_iter_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00; t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv, base;
    inv = 8'h01; base = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) b[w+4*c] = a[w + 4*((c+w)%4)];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int w = 0; w < 4; w++) m[w+4*c] = b[w+4*c];
      end else begin
        m[4*c+0] = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i] ^ k[127-8*i -: 8];
    return r;
  endfunction

  logic [31:0]  w [0:59];
  logic [127:0] rk10 [0:10];
  logic [127:0] rk14 [0:14];

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref10(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk10[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk10[r], r == 10);
    return s;
  endfunction

  // ---------------- DUT, Nr = 10 ----------------
  logic         in_valid, in_ready, rnd_final, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_in, rnd_state, rnd_out, out_data;
  logic [3:0]   rk_idx;

  assign rk_in   = rk10[rk_idx];
  assign rnd_out = aes_round(rnd_state, rk_in, rnd_final);

  aes_iter_ctrl #(.Nr(10), .RW(4)) u_dut (
    .clk_i(clk), .reset_ni(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .rk_idx_o(rk_idx), .rk_in_i(rk_in),
    .rnd_state_o(rnd_state), .rnd_final_o(rnd_final), .rnd_out_i(rnd_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy)
  );

  // ---------------- DUT, Nr = 14 ----------------
  logic         in_valid14, in_ready14, rnd_final14, out_valid14, out_ready14, busy14;
  logic [127:0] in_data14, rk_in14, rnd_state14, rnd_out14, out_data14;
  logic [3:0]   rk_idx14;

  assign rk_in14   = rk14[rk_idx14];
  assign rnd_out14 = aes_round(rnd_state14, rk_in14, rnd_final14);

  aes_iter_ctrl #(.Nr(14), .RW(4)) u_dut14 (
    .clk_i(clk), .reset_ni(reset_n),
    .in_valid_i(in_valid14), .in_ready_o(in_ready14), .in_data_i(in_data14),
    .rk_idx_o(rk_idx14), .rk_in_i(rk_in14),
    .rnd_state_o(rnd_state14), .rnd_final_o(rnd_final14), .rnd_out_i(rnd_out14),
    .out_valid_o(out_valid14), .out_ready_i(out_ready14), .out_data_o(out_data14),
    .busy_o(busy14)
  );

  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_B2  = 128'hffeeddccbbaa99887766554433221100;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one block through the Nr=10 instance, starting in IDLE. Checks the
  // per-cycle rk_idx / rnd_final / in_ready / busy sequence, the latency
  // (cycles from the accept cycle to the first out_valid cycle, accept cycle
  // included) and the ciphertext. Returns in the first DONE cycle.
  task automatic blk10(input logic [127:0] pt, input logic [127:0] exp,
                       input bit keep_valid, input bit noise, input string nm);
    int lat;
    lat = 0;
    in_valid = 1'b1;
    in_data  = pt;
    for (int k = 0; k < 20 && lat == 0; k++) begin
      if (k <= 10) begin
        tests++; if (rk_idx !== 4'(k)) begin fails++;
          $display("FAIL %s rk_idx c%0d: got %0d expected %0d", nm, k, rk_idx, k); end
        tests++; if (rnd_final !== (k == 10)) begin fails++;
          $display("FAIL %s rnd_final c%0d: got %b expected %b", nm, k, rnd_final, k == 10); end
        tests++; if (in_ready !== (k == 0)) begin fails++;
          $display("FAIL %s in_ready c%0d: got %b expected %b", nm, k, in_ready, k == 0); end
        tests++; if (busy !== (k != 0)) begin fails++;
          $display("FAIL %s busy c%0d: got %b expected %b", nm, k, busy, k != 0); end
      end
      tick;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else if (!keep_valid) begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) lat = k + 1;
    end
    if (!keep_valid) in_valid = 1'b0;
    tests++; if (lat != 11) begin fails++;
      $display("FAIL %s latency: got %0d expected 11", nm, lat); end
    tests++; if (out_data !== exp) begin fails++;
      $display("FAIL %s out_data: got %h expected %h", nm, out_data, exp); end
    $display("[TB] %s: block %h done, latency %0d", nm, pt, lat);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
    tests++; if (rnd_final !== 1'b0) begin fails++; $display("FAIL reset rnd_final: got %b expected 0", rnd_final); end
    tests++; if (rk_idx !== 4'd0) begin fails++; $display("FAIL reset rk_idx: got %0d expected 0", rk_idx); end
    tests++; if (out_data !== 128'h0) begin fails++; $display("FAIL reset out_data: got %h expected 0", out_data); end
    tests++; if (in_ready14 !== 1'b1) begin fails++; $display("FAIL reset in_ready14: got %b expected 1", in_ready14); end
    reset_n = 1'b1;
    repeat (2) tick;
    $display("[TB] reset: state checked");
  endtask

  task automatic test_fips128;
    out_ready = 1'b1;
    blk10(PT_C, CT_C1, 1'b0, 1'b0, "fips128");
    tick;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++;
      $display("FAIL fips128 post-handshake: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back;
    int a0, a1, a2;
    out_ready = 1'b1;
    a0 = cyc; blk10(PT_C,  CT_C1,        1'b1, 1'b0, "b2b0"); tick;
    a1 = cyc; blk10(PT_B1, ref10(PT_B1), 1'b1, 1'b0, "b2b1"); tick;
    a2 = cyc; blk10(PT_B2, ref10(PT_B2), 1'b1, 1'b0, "b2b2");
    in_valid = 1'b0;
    tick;
    tests++; if (a1 - a0 != 12) begin fails++; $display("FAIL b2b interval1: got %0d expected 12", a1 - a0); end
    tests++; if (a2 - a1 != 12) begin fails++; $display("FAIL b2b interval2: got %0d expected 12", a2 - a1); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b idle in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_backpressure;
    logic [127:0] exp;
    exp = ref10(PT_B1);
    out_ready = 1'b0;
    blk10(PT_B1, exp, 1'b0, 1'b1, "bp");
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin fails++;
        $display("FAIL bp hold c%0d: got vld=%b rdy=%b busy=%b expected 1 0 1", i, out_valid, in_ready, busy); end
      tests++; if (out_data !== exp) begin fails++;
        $display("FAIL bp stable c%0d: got %h expected %h", i, out_data, exp); end
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || rk_idx !== 4'd0) begin fails++;
      $display("FAIL bp release: got vld=%b rdy=%b busy=%b idx=%0d expected 0 1 0 0", out_valid, in_ready, busy, rk_idx); end
    $display("[TB] bp: 20 stall cycles, released");
  endtask

  task automatic test_reset_mid_op;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = PT_B2;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    tests++; if (rk_idx !== 4'd5) begin fails++; $display("FAIL rstmid round: got %0d expected 5", rk_idx); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL rstmid async: got vld=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy); end
    tests++; if (rnd_state !== 128'h0 || rk_idx !== 4'd0) begin fails++;
      $display("FAIL rstmid state: got %h idx=%0d expected 0 idx=0", rnd_state, rk_idx); end
    tick;
    // Release between edges; the block is then accepted on the first edge.
    @(negedge clk);
    reset_n = 1'b1;
    blk10(PT_C, CT_C1, 1'b0, 1'b0, "rstmid");
    tick;
  endtask

  task automatic test_aes256;
    int lat;
    lat = 0;
    out_ready14 = 1'b1;
    in_valid14  = 1'b1;
    in_data14   = PT_C;
    for (int k = 0; k < 25 && lat == 0; k++) begin
      if (k <= 14) begin
        tests++; if (rk_idx14 !== 4'(k)) begin fails++;
          $display("FAIL aes256 rk_idx c%0d: got %0d expected %0d", k, rk_idx14, k); end
        tests++; if (rnd_final14 !== (k == 14)) begin fails++;
          $display("FAIL aes256 rnd_final c%0d: got %b expected %b", k, rnd_final14, k == 14); end
      end
      tick;
      in_valid14 = 1'b0;
      if (out_valid14 === 1'b1) lat = k + 1;
    end
    tests++; if (lat != 15) begin fails++; $display("FAIL aes256 latency: got %0d expected 15", lat); end
    tests++; if (out_data14 !== CT_C3) begin fails++;
      $display("FAIL aes256 out_data: got %h expected %h", out_data14, CT_C3); end
    tick;
    tests++; if (out_valid14 !== 1'b0 || in_ready14 !== 1'b1) begin fails++;
      $display("FAIL aes256 post: got vld=%b rdy=%b expected 0 1", out_valid14, in_ready14); end
    $display("[TB] aes256: latency %0d, ct %h", lat, out_data14);
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
    reset_n = 1'b0;
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    test_reset();
    test_fips128();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_aes256();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
